vector_assembler: RTL and testbench

Streaming successor to the single-shot vector constructor. Accepts a job of `expected_elements` fixed-point elements over a valid/ready stream and packs them into `VECTOR_DIMENSION`-wide vectors. Vectors go through a two-stage buffer, an assembly register plus an output register, so input keeps flowing while the downstream multiplier holds a vector. A short final vector is zero-padded, flagged `vector_last`, and reports how many of its slots are real. Sits between the element fetch path and the vector multiplier datapath.

---
 rtl/vector_pkg.sv | 17 +
 rtl/vector_slot_buffer.sv | 78 +++++++
 rtl/vector_assembler.sv | 163 ++++++++++++++++
 tb/tb_vector_assembler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared defaults, FSM state type and element type for the vector assembler.
package vector_pkg;

  localparam int unsigned DefaultElementWidth    = 24;
  localparam int unsigned DefaultVectorDimension = 3;
  localparam int unsigned DefaultCountWidth      = 16;
  localparam int unsigned DefaultAddrWidth       = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } vec_asm_state_t;

  typedef logic [DefaultElementWidth-1:0] element_t;

endpackage

// File: rtl/vector_slot_buffer.sv
// One vector worth of element slots plus fill/last tags.
// Clear, load and indexed write may coincide; later operations override earlier ones.
module vector_slot_buffer
  import vector_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH    = DefaultElementWidth,
  parameter int unsigned VECTOR_DIMENSION = DefaultVectorDimension,
  parameter int unsigned FILL_WIDTH       = $clog2(VECTOR_DIMENSION + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic [ELEMENT_WIDTH-1:0] load_slots [0:VECTOR_DIMENSION-1],
  input  logic [FILL_WIDTH-1:0]    load_fill,
  input  logic                     load_last,
  input  logic                     wr_en,
  input  logic [FILL_WIDTH-1:0]    wr_idx,
  input  logic [ELEMENT_WIDTH-1:0] wr_data,
  input  logic [FILL_WIDTH-1:0]    wr_fill,
  input  logic                     wr_last,
  output logic [ELEMENT_WIDTH-1:0] slots [0:VECTOR_DIMENSION-1],
  output logic [FILL_WIDTH-1:0]    fill,
  output logic                     last
);

  logic [ELEMENT_WIDTH-1:0] slots_d [0:VECTOR_DIMENSION-1];
  logic [ELEMENT_WIDTH-1:0] slots_q [0:VECTOR_DIMENSION-1];
  logic [FILL_WIDTH-1:0]    fill_d, fill_q;
  logic                     last_d, last_q;

  always_comb begin
    slots_d = slots_q;
    fill_d  = fill_q;
    last_d  = last_q;
    if (clear) begin
      for (int i = 0; i < VECTOR_DIMENSION; i++) begin
        slots_d[i] = '0;
      end
      fill_d = '0;
      last_d = 1'b0;
    end
    if (load) begin
      slots_d = load_slots;
      fill_d  = load_fill;
      last_d  = load_last;
    end
    // A write on the same edge as a clear lands in the freshly zeroed buffer.
    if (wr_en) begin
      for (int i = 0; i < VECTOR_DIMENSION; i++) begin
        if (wr_idx == FILL_WIDTH'(i)) begin
          slots_d[i] = wr_data;
        end
      end
      fill_d = wr_fill;
      last_d = wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < VECTOR_DIMENSION; i++) begin
        slots_q[i] <= '0;
      end
      fill_q <= '0;
      last_q <= 1'b0;
    end else begin
      slots_q <= slots_d;
      fill_q  <= fill_d;
      last_q  <= last_d;
    end
  end

  assign slots = slots_q;
  assign fill  = fill_q;
  assign last  = last_q;

endmodule

// File: rtl/vector_assembler.sv
// Streams a job of elements into VECTOR_DIMENSION-wide vectors through an assembly
// register and an output register, zero-padding and tagging the final short vector.
module vector_assembler
  import vector_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH    = DefaultElementWidth,
  parameter int unsigned ADDR_WIDTH       = DefaultAddrWidth,
  parameter int unsigned VECTOR_DIMENSION = DefaultVectorDimension,
  parameter int unsigned COUNT_WIDTH      = DefaultCountWidth,
  parameter int unsigned FILL_WIDTH       = $clog2(VECTOR_DIMENSION + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [COUNT_WIDTH-1:0]   expected_elements,
  input  logic [ELEMENT_WIDTH-1:0] element_in,
  input  logic                     element_valid,
  output logic                     element_ready,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [ELEMENT_WIDTH-1:0] vector [0:VECTOR_DIMENSION-1],
  output logic                     vector_valid,
  input  logic                     vector_accept,
  output logic                     vector_last,
  output logic [FILL_WIDTH-1:0]    vector_fill,
  output logic                     busy,
  output logic                     done
);

  vec_asm_state_t           state_d, state_q;
  logic [COUNT_WIDTH-1:0]   rem_d, rem_q;
  logic [ADDR_WIDTH-1:0]    addr_d, addr_q;
  logic [FILL_WIDTH-1:0]    asm_idx_d, asm_idx_q;
  logic                     out_valid_d, out_valid_q;

  logic                     start_ok;
  logic                     asm_complete;
  logic                     move;
  logic                     out_taken;
  logic                     elem_xfer;
  logic [FILL_WIDTH-1:0]    wr_idx;
  logic [FILL_WIDTH-1:0]    wr_fill;
  logic                     wr_last;

  logic [ELEMENT_WIDTH-1:0] asm_slots  [0:VECTOR_DIMENSION-1];
  logic [ELEMENT_WIDTH-1:0] zero_slots [0:VECTOR_DIMENSION-1];
  logic [FILL_WIDTH-1:0]    asm_fill;
  logic                     asm_last;

  assign zero_slots = '{default: '0};

  // Complete when full, or when the job has run out with a partial vector pending.
  assign asm_complete = (asm_idx_q == FILL_WIDTH'(VECTOR_DIMENSION)) ||
                        ((rem_q == '0) && (asm_idx_q != '0));
  assign out_taken    = out_valid_q && vector_accept;
  assign move         = asm_complete && (!out_valid_q || vector_accept);
  assign start_ok     = start && (state_q != StRun);

  assign element_ready = (state_q == StRun) && (rem_q != '0) && (!asm_complete || move);
  assign elem_xfer     = element_valid && element_ready;

  assign wr_idx  = move ? '0 : asm_idx_q;
  assign wr_fill = wr_idx + FILL_WIDTH'(1);
  assign wr_last = (rem_q == COUNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    asm_idx_d   = asm_idx_q;
    out_valid_d = out_valid_q;

    if (start_ok) begin
      state_d   = (expected_elements == '0) ? StDone : StRun;
      rem_d     = expected_elements;
      addr_d    = '0;
      asm_idx_d = '0;
    end else begin
      if (move) begin
        asm_idx_d = '0;
      end
      if (elem_xfer) begin
        asm_idx_d = wr_idx + FILL_WIDTH'(1);
        rem_d     = rem_q - COUNT_WIDTH'(1);
        addr_d    = addr_q + ADDR_WIDTH'(1);
      end
      if (state_q == StRun && out_taken && vector_last) begin
        state_d = StDone;
      end
    end

    if (move) begin
      out_valid_d = 1'b1;
    end else if (out_taken) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      addr_q      <= '0;
      asm_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      asm_idx_q   <= asm_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  vector_slot_buffer #(
    .ELEMENT_WIDTH   (ELEMENT_WIDTH),
    .VECTOR_DIMENSION(VECTOR_DIMENSION),
    .FILL_WIDTH      (FILL_WIDTH)
  ) u_asm_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok || move),
    .load      (1'b0),
    .load_slots(zero_slots),
    .load_fill ('0),
    .load_last (1'b0),
    .wr_en     (elem_xfer),
    .wr_idx    (wr_idx),
    .wr_data   (element_in),
    .wr_fill   (wr_fill),
    .wr_last   (wr_last),
    .slots     (asm_slots),
    .fill      (asm_fill),
    .last      (asm_last)
  );

  vector_slot_buffer #(
    .ELEMENT_WIDTH   (ELEMENT_WIDTH),
    .VECTOR_DIMENSION(VECTOR_DIMENSION),
    .FILL_WIDTH      (FILL_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load      (move),
    .load_slots(asm_slots),
    .load_fill (asm_fill),
    .load_last (asm_last),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .wr_fill   ('0),
    .wr_last   (1'b0),
    .slots     (vector),
    .fill      (vector_fill),
    .last      (vector_last)
  );

  assign addr         = addr_q;
  assign vector_valid = out_valid_q;
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_vector_assembler.sv
// Directed bench for vector_assembler: full-rate, short tail, backpressure, zero-length,
// reset mid-job and addr wrap (second instance with a 3-bit addr).
module tb_vector_assembler;
  import vector_pkg::*;

  localparam int unsigned EW = 24;
  localparam int unsigned D  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   expected_elements;
  logic [EW-1:0] element_in;
  logic          element_valid;
  logic          vector_accept;

  logic          element_ready, vector_valid, vector_last, busy, done;
  logic [7:0]    addr;
  logic [EW-1:0] vector [0:D-1];
  logic [1:0]    vector_fill;

  logic          w_element_ready, w_vector_valid, w_vector_last, w_busy, w_done;
  logic [2:0]    w_addr;
  logic [EW-1:0] w_vector [0:D-1];
  logic [1:0]    w_vector_fill;

  int n_checks = 0;
  int n_errors = 0;

  element_t        elems[$];
  logic [3*EW-1:0] got_v[$];
  logic [1:0]      got_fill[$];
  logic            got_last[$];
  logic [7:0]      addr_log[$];
  logic [2:0]      w_addr_log[$];
  int              job_cycles, last_acc_cyc, stalls, first_drop, unstable;

  always #5 clk = ~clk;

  vector_assembler u_dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .expected_elements(expected_elements),
    .element_in       (element_in),
    .element_valid    (element_valid),
    .element_ready    (element_ready),
    .addr             (addr),
    .vector           (vector),
    .vector_valid     (vector_valid),
    .vector_accept    (vector_accept),
    .vector_last      (vector_last),
    .vector_fill      (vector_fill),
    .busy             (busy),
    .done             (done)
  );

  vector_assembler #(
    .ADDR_WIDTH(3)
  ) u_dut_w (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .expected_elements(expected_elements),
    .element_in       (element_in),
    .element_valid    (element_valid),
    .element_ready    (w_element_ready),
    .addr             (w_addr),
    .vector           (w_vector),
    .vector_valid     (w_vector_valid),
    .vector_accept    (vector_accept),
    .vector_last      (w_vector_last),
    .vector_fill      (w_vector_fill),
    .busy             (w_busy),
    .done             (w_done)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*EW-1:0] pack3(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                            input logic [EW-1:0] c);
    return {a, b, c};
  endfunction

  // Runs one job; accept held low for the first `hold` cycles; optional ignored start.
  task automatic run_job(input int n, input int hold, input int mid_start_at);
    int idx = 0;
    int cyc = 0;
    logic xfer;
    logic have_ref = 1'b0;
    logic [3*EW-1:0] ref_v = '0;
    got_v.delete(); got_fill.delete(); got_last.delete();
    addr_log.delete(); w_addr_log.delete();
    stalls = 0; first_drop = -1; unstable = 0; last_acc_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    expected_elements = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    element_valid = (n > 0);
    element_in = (n > 0) ? elems[0] : '0;
    vector_accept = (hold == 0);
    while (!done && cyc < 300) begin
      @(negedge clk);
      xfer = element_valid && element_ready;
      if (element_valid && !element_ready) begin
        stalls++;
        if (first_drop < 0) first_drop = idx;
      end
      if (xfer) begin
        addr_log.push_back(addr);
        w_addr_log.push_back(w_addr);
      end
      if (vector_valid && !vector_accept) begin
        if (!have_ref) begin
          have_ref = 1'b1;
          ref_v = pack3(vector[0], vector[1], vector[2]);
        end else if (ref_v != pack3(vector[0], vector[1], vector[2])) begin
          unstable++;
        end
      end
      if (vector_valid && vector_accept) begin
        got_v.push_back(pack3(vector[0], vector[1], vector[2]));
        got_fill.push_back(vector_fill);
        got_last.push_back(vector_last);
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        idx++;
        if (idx < n) element_in = elems[idx];
        else element_valid = 1'b0;
      end
      vector_accept = (cyc >= hold);
      start = (cyc == mid_start_at);
      if (cyc == mid_start_at) expected_elements = 16'd3;
    end
    start = 1'b0;
    element_valid = 1'b0;
    vector_accept = 1'b0;
    job_cycles = cyc;
    check_eq("job_finished", {95'd0, done}, 96'd1);
  endtask

  task automatic check_vec(input string tag, input int k, input logic [3*EW-1:0] exp_v,
                           input logic [1:0] exp_fill, input logic exp_last);
    check_eq({tag, "_data"}, 96'(got_v[k]), 96'(exp_v));
    check_eq({tag, "_fill"}, 96'(got_fill[k]), 96'(exp_fill));
    check_eq({tag, "_last"}, 96'(got_last[k]), 96'(exp_last));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, 96'(element_ready), 96'd0);
    check_eq({tag, "_addr"}, 96'(addr), 96'd0);
    check_eq({tag, "_vector"}, 96'(pack3(vector[0], vector[1], vector[2])), 96'd0);
    check_eq({tag, "_valid"}, 96'(vector_valid), 96'd0);
    check_eq({tag, "_last"}, 96'(vector_last), 96'd0);
    check_eq({tag, "_fill"}, 96'(vector_fill), 96'd0);
    check_eq({tag, "_busy"}, 96'(busy), 96'd0);
    check_eq({tag, "_done"}, 96'(done), 96'd0);
  endtask

  initial begin
    int vv;
    reset = 1'b1; start = 1'b0; expected_elements = '0;
    element_in = '0; element_valid = 1'b0; vector_accept = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("rst");

    // Full-rate job.
    elems = '{24'hAA00, 24'h1B480, 24'h5916, 24'h15F0, 24'h45557E, 24'h20000};
    run_job(6, 0, -1);
    check_eq("full_nvec", 96'(got_v.size()), 96'd2);
    check_vec("full_v0", 0, pack3(24'hAA00, 24'h1B480, 24'h5916), 2'd3, 1'b0);
    check_vec("full_v1", 1, pack3(24'h15F0, 24'h45557E, 24'h20000), 2'd3, 1'b1);
    check_eq("full_stalls", 96'(stalls), 96'd0);
    check_eq("full_done_lat", 96'(job_cycles), 96'(last_acc_cyc + 1));
    check_eq("full_busy", 96'(busy), 96'd0);

    // Short tail.
    elems = '{24'h11, 24'h22, 24'h33, 24'h44};
    run_job(4, 0, -1);
    check_eq("tail_nvec", 96'(got_v.size()), 96'd2);
    check_vec("tail_v0", 0, pack3(24'h11, 24'h22, 24'h33), 2'd3, 1'b0);
    check_vec("tail_v1", 1, pack3(24'h44, 24'h0, 24'h0), 2'd1, 1'b1);

    // Backpressure.
    elems = '{24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6, 24'h7, 24'h8, 24'h9};
    run_job(9, 10, -1);
    check_eq("bp_first_drop", 96'(first_drop), 96'd6);
    check_eq("bp_stable", 96'(unstable), 96'd0);
    check_eq("bp_nvec", 96'(got_v.size()), 96'd3);
    check_vec("bp_v0", 0, pack3(24'h1, 24'h2, 24'h3), 2'd3, 1'b0);
    check_vec("bp_v1", 1, pack3(24'h4, 24'h5, 24'h6), 2'd3, 1'b0);
    check_vec("bp_v2", 2, pack3(24'h7, 24'h8, 24'h9), 2'd3, 1'b1);
    check_eq("bp_addr", 96'(addr), 96'd9);

    // Zero-length job.
    run_job(0, 0, -1);
    check_eq("zero_done_lat", 96'(job_cycles), 96'd0);
    vv = 0;
    repeat (4) begin
      @(negedge clk);
      if (vector_valid) vv++;
    end
    check_eq("zero_no_valid", 96'(vv), 96'd0);
    check_eq("zero_done_held", 96'(done), 96'd1);

    // Reset after the 2nd element of a 5-element job.
    @(posedge clk); #1;
    start = 1'b1; expected_elements = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("rj_ready_after_start", 96'(element_ready), 96'd1);
    element_valid = 1'b1; element_in = 24'hA1; vector_accept = 1'b1;
    @(posedge clk); #1;
    element_in = 24'hA2;
    @(posedge clk); #1;
    element_valid = 1'b0;
    check_eq("rj_addr_pre", 96'(addr), 96'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vector_accept = 1'b0;
    check_reset_state("rj");
    elems = '{24'hB1, 24'hB2, 24'hB3};
    run_job(3, 0, -1);
    check_eq("rj_nvec", 96'(got_v.size()), 96'd1);
    check_vec("rj_v0", 0, pack3(24'hB1, 24'hB2, 24'hB3), 2'd3, 1'b1);
    check_eq("rj_addr0", 96'(addr_log[0]), 96'd0);

    // addr wrap on the 3-bit instance, with an ignored start mid-job.
    elems = '{};
    for (int i = 0; i < 10; i++) elems.push_back(element_t'(24'h100 + i));
    run_job(10, 0, 4);
    check_eq("wrap_nxfer", 96'(w_addr_log.size()), 96'd10);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("wrap_addr%0d", i), 96'(w_addr_log[i]), 96'(i % 8));
    end
    check_eq("wrap_nvec", 96'(got_v.size()), 96'd4);
    check_eq("wrap_w_vector", 96'(pack3(w_vector[0], w_vector[1], w_vector[2])),
             96'(pack3(24'h109, 24'h0, 24'h0)));
    check_eq("wrap_w_tags", 96'({w_vector_fill, w_vector_last, w_vector_valid, w_element_ready,
                                 w_busy, w_done}), 96'(7'b01_1_0_0_0_1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
